fir_tap_multiplier: RTL
=======================

# fir_tap_multiplier

32-tap sample delay line and coefficient multiplier array for the FIR datapath. It accepts one signed 16-bit sample per handshake and shifts it into a 32-deep history. It multiplies every tap by its programmable signed 20-bit coefficient and presents the 32 registered 36-bit products to the downstream combinational 32-input tree adder. A valid/ready handshake on each side lets the block stall under downstream backpressure without losing samples.

## Interface
- TAPS, 32, number of taps. Fixed; the downstream adder takes exactly 32 operands.
- XW, 16, sample width (signed).
- CW, 20, coefficient width (signed).
- PW, 36, product width, XW+CW.
- clk  in  1  rising-edge clock, single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  x_in holds a sample.
- in_ready  out  1  block can accept a sample this cycle.
- x_in  in  16  signed sample.
- flush  in  1  synchronous clear of delay line and prime counter.
- coef_wr  in  1  coefficient write strobe.
- coef_addr  in  5  tap index to write.
- coef_data  in  20  signed coefficient.
- out_valid  out  1  prod_flat holds a valid product set.
- out_ready  in  1  downstream consumes the product set.
- prod_flat  out  1152  products; tap k occupies bits [36k+35:36k].
- primed  out  1  high once 32 samples have been accepted since reset or flush.

## Operation
- Delay line d[0..31], where d[0] is the newest sample. Coefficient bank c[0..31].
- Accept condition: in_valid && in_ready. On accept:
  - d[0] <= x_in; d[k] <= d[k-1] for k=1..31. d[31] is discarded.
  - prod[k] <= signed(d_next[k]) * signed(c[k]), where d_next is the post-shift line. prod[0] uses x_in.
  - out_valid <= 1.
- in_ready = !out_valid || out_ready. This is a single output register with no skid buffer.
- On out_valid && out_ready with no accept in the same cycle: out_valid <= 0, and the products hold their old values.
- Arithmetic: a full-precision 16x20 signed multiply into 36 bits. It cannot overflow; no rounding or saturation.
- Warm-up: history starts at zero, so the first 31 product sets are zero-padded, not suppressed.
- Prime counter (6-bit) increments on accept and saturates at 32. primed = (count == 32).
- Coefficient write: c[coef_addr] <= coef_data, effective from the next edge.
  - A write in the same cycle as an accept uses the OLD c[coef_addr] for that product set.
  - Writes are permitted at any time and do not affect out_valid or a product set already held.
- Flush: clears d[*] to 0, count to 0, and out_valid to 0.
  - Flush has priority over a simultaneous accept; that sample is dropped.
  - in_ready still reflects the pre-flush state that cycle.
  - Coefficients are not affected.
- Reset (async, rst_n=0): d[*]=0, c[*]=0, prod[*]=0, out_valid=0, count=0, primed=0. in_ready=1 combinationally after reset.
- Reset mid-operation: any held product set is lost and must not be re-presented after release.

## Timing
- Latency is 1 cycle. A sample accepted at edge n appears in prod_flat with out_valid=1 from just after edge n until the handshake completes.
- Throughput is one sample per cycle while out_ready=1.
- Stall: while out_valid && !out_ready, in_ready=0, and prod_flat and out_valid are held stable.
- Downstream takes bits [31:16] of the 36-bit sum. With coefficients at 65536 (1.0 in Q4.16), the adder output is the plain sum of taps.
- No combinational path from x_in to any output. The only input-to-output combinational path is out_ready to in_ready.

## Test plan
- Reset then ramp:
  - Stimulus: all c=65536; accept samples 1,2,…,40 with out_ready=1.
  - Required: prod[k] = d[k]·65536 per accept; after sample n, prod[0]=n·65536.
  - Required: primed rises on the 32nd accept; after sample 40, taps hold 40..9.
- Impulse response:
  - Stimulus: c[k]=k-16; accept x=1000, then 31 zeros.
  - Required: on the j-th product set, only prod[j]=1000·(j-16) is nonzero.
- Extremes:
  - Stimulus: c[5]=-524288, x=-32768 at tap 5.
  - Required: prod[5]=+17179869184 (0x4_0000_0000).
  - Stimulus: c[5]=524287, x=-32768.
  - Required: prod[5]=-17179836416.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles with in_valid=1.
  - Required: in_ready=0, prod_flat stable, no sample lost.
  - Required: on release, the next accept shifts exactly one sample.
- Same-cycle events:
  - Stimulus: coef write to c[0] with an accept of x=3.
  - Required: prod[0] uses the old coefficient; the next accept uses the new one.
  - Stimulus: flush with an accept.
  - Required: sample dropped, d=0, out_valid=0, primed=0.
- Async reset mid-stall:
  - Stimulus: pulse rst_n low while out_valid=1 and out_ready=0.
  - Required: all outputs zero immediately; in_ready=1 after release.

Source files
------------

// File: rtl/fir_tap_multiplier_if.sv
// Sample-in / product-set-out handshakes plus coefficient write and flush controls.
// master drives samples, coefficients and out_ready; slave is the tap multiplier.
interface fir_tap_multiplier_if #(
    parameter int TAPS = 32,
    parameter int XW   = 16,
    parameter int CW   = 20,
    parameter int PW   = XW + CW,
    parameter int AW   = $clog2(TAPS)
);
    logic               in_valid;
    logic               in_ready;
    logic [XW-1:0]      x_in;
    logic               flush;
    logic               coef_wr;
    logic [AW-1:0]      coef_addr;
    logic [CW-1:0]      coef_data;
    logic               out_valid;
    logic               out_ready;
    logic [TAPS*PW-1:0] prod_flat;
    logic               primed;

    modport master (
        output in_valid, x_in, flush, coef_wr, coef_addr, coef_data, out_ready,
        input  in_ready, out_valid, prod_flat, primed
    );

    modport slave (
        input  in_valid, x_in, flush, coef_wr, coef_addr, coef_data, out_ready,
        output in_ready, out_valid, prod_flat, primed
    );
endinterface

// File: rtl/fir_tap_multiplier.sv
// 32-tap delay line; each tap times its signed coefficient into registered 36-bit products.
// Latency: 1 cycle from accepted sample to product set on prod_flat.
// Backpressure: single output register, in_ready = !out_valid || out_ready; stalls hold products.
module fir_tap_multiplier #(
    parameter int TAPS = 32,
    parameter int XW   = 16,
    parameter int CW   = 20,
    parameter int PW   = XW + CW,
    parameter int AW   = $clog2(TAPS)
) (
    input logic                 clk,
    input logic                 rst_n,
    fir_tap_multiplier_if.slave bus
);
    localparam int CNTW = $clog2(TAPS + 1);

    logic [TAPS-1:0][XW-1:0] d_q;
    logic [TAPS-1:0][XW-1:0] d_nxt;
    logic [TAPS-1:0][CW-1:0] c_q;
    logic [TAPS-1:0][PW-1:0] prod_q;
    logic [TAPS-1:0][PW-1:0] prod_nxt;
    logic                    out_valid_q;
    logic [CNTW-1:0]         cnt_q;
    logic                    in_ready;
    logic                    accept;

    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    // Products are formed from the post-shift line so prod[0] sees x_in directly.
    always_comb begin
        d_nxt    = '0;
        prod_nxt = '0;
        d_nxt[0] = bus.x_in;
        for (int k = 1; k < TAPS; k++) begin
            d_nxt[k] = d_q[k-1];
        end
        for (int k = 0; k < TAPS; k++) begin
            prod_nxt[k] = $signed({{(PW-XW){d_nxt[k][XW-1]}}, d_nxt[k]})
                        * $signed({{(PW-CW){c_q[k][CW-1]}}, c_q[k]});
        end
    end

    // Flush wins over a same-cycle accept; the held products are simply invalidated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q         <= '0;
            prod_q      <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else if (bus.flush) begin
            d_q         <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else if (accept) begin
            d_q         <= d_nxt;
            prod_q      <= prod_nxt;
            out_valid_q <= 1'b1;
            if (cnt_q != CNTW'(TAPS)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Coefficient writes land after this edge's products are captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= '0;
        end else if (bus.coef_wr) begin
            c_q[bus.coef_addr] <= bus.coef_data;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.prod_flat = prod_q;
    assign bus.primed    = (cnt_q == CNTW'(TAPS));
endmodule
